rv32i_two_stage_core: RTL and testbench

// - 2-stage pipelined RV32I integer core (top level of the processor).
// - Stage IF: PC register drives pc_out; the external instruction memory returns `instruction` combinationally.
// - Stage EX: one cycle does decode, register-file read, ALU, data-memory access and write-back.
// - Data memory and the 32x32 register file are internal.

---
 rtl/rv32i_two_stage_core.sv | 111 +++++++++++
 tb/tb_rv32i_two_stage_core.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rv32i_two_stage_core.sv
// rv32i_two_stage_core: two-stage RV32I core (IF, then EX doing decode/ALU/memory/write-back in one cycle).
// Register file and data memory are internal; instruction memory is external and combinational.
module rv32i_two_stage_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] res_out
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0] r_pc, r_ir, r_ex_pc;
    logic [31:0] r_rf [1:31];
    logic [31:0] r_dmem [0:DMEM_WORDS-1];

    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_sh;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_a, w_b, w_y, w_alu, w_sra, w_ld, w_wd, w_target;
    logic [AW-1:0] w_widx;
    logic w_is_op, w_is_opi, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;
    logic w_lt, w_ltu, w_taken, w_redirect, w_we;

    assign w_op  = r_ir[6:0];
    assign w_rd  = r_ir[11:7];
    assign w_f3  = r_ir[14:12];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_f7  = r_ir[31:25];

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u = {r_ir[31:12], 12'h000};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    assign w_a = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
    assign w_b = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

    // Anything not matching a legal encoding falls through with every enable low, i.e. a NOP.
    assign w_is_op    = (w_op == 7'h33) && (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)));
    assign w_is_opi   = (w_op == 7'h13) && (w_f3 == 3'd1 ? w_f7 == 7'h00 :
                                            w_f3 == 3'd5 ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1);
    assign w_is_lw    = (w_op == 7'h03) && (w_f3 == 3'd2);
    assign w_is_sw    = (w_op == 7'h23) && (w_f3 == 3'd2);
    assign w_is_br    = (w_op == 7'h63) && (w_f3 != 3'd2) && (w_f3 != 3'd3);
    assign w_is_jal   = (w_op == 7'h6F);
    assign w_is_jalr  = (w_op == 7'h67) && (w_f3 == 3'd0);
    assign w_is_lui   = (w_op == 7'h37);
    assign w_is_auipc = (w_op == 7'h17);

    assign w_y   = w_is_op ? w_b : w_imm_i;
    assign w_sh  = w_y[4:0];
    assign w_sra = $signed(w_a) >>> w_sh;

    always_comb begin
        case (w_f3)
            3'd0:    w_alu = (w_is_op && w_f7[5]) ? w_a - w_y : w_a + w_y;
            3'd1:    w_alu = w_a << w_sh;
            3'd2:    w_alu = {31'd0, $signed(w_a) < $signed(w_y)};
            3'd3:    w_alu = {31'd0, w_a < w_y};
            3'd4:    w_alu = w_a ^ w_y;
            3'd5:    w_alu = w_f7[5] ? w_sra : w_a >> w_sh;
            3'd6:    w_alu = w_a | w_y;
            default: w_alu = w_a & w_y;
        endcase
    end

    // f3[2] selects magnitude vs equality, f3[1] unsigned, f3[0] inverts the sense.
    assign w_lt    = $signed(w_a) < $signed(w_b);
    assign w_ltu   = w_a < w_b;
    assign w_taken = w_is_br && (w_f3[2] ? ((w_f3[1] ? w_ltu : w_lt) ^ w_f3[0]) : ((w_a == w_b) ^ w_f3[0]));

    assign w_widx = AW'((w_a + (w_is_sw ? w_imm_s : w_imm_i)) >> 2);
    assign w_ld   = r_dmem[w_widx];

    assign w_redirect = w_taken || w_is_jal || w_is_jalr;
    assign w_target   = w_is_jalr ? ((w_a + w_imm_i) & ~32'd1) : r_ex_pc + (w_is_jal ? w_imm_j : w_imm_b);

    assign w_we = w_is_op || w_is_opi || w_is_lw || w_is_jal || w_is_jalr || w_is_lui || w_is_auipc;
    assign w_wd = w_is_lui                 ? w_imm_u :
                  w_is_auipc               ? r_ex_pc + w_imm_u :
                  (w_is_jal || w_is_jalr)  ? r_ex_pc + 32'd4 :
                  w_is_lw                  ? w_ld : w_alu;

    assign pc_out  = r_pc;
    assign res_out = w_we ? w_wd : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_ir    <= NOP;
            r_ex_pc <= 32'd0;
            for (int i = 1; i < 32; i++) r_rf[i] <= 32'd0;
        end else begin
            r_pc    <= w_redirect ? w_target : r_pc + 32'd4;
            r_ir    <= w_redirect ? NOP : instruction;
            r_ex_pc <= r_pc;
            if (w_we && w_rd != 5'd0) r_rf[w_rd] <= w_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (w_is_sw) r_dmem[w_widx] <= w_b;
    end
endmodule

// File: tb/tb_rv32i_two_stage_core.sv
// tb_rv32i_two_stage_core: directed programs; expected {pc_out, res_out} per cycle are queued
// by the stimulus and checked by an independent monitor on each falling edge.
module tb_rv32i_two_stage_core;
    logic        clk, rst;
    logic [31:0] instruction, pc_out, res_out;
    logic [31:0] imem [0:63];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;

    rv32i_two_stage_core dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_out(pc_out), .res_out(res_out)
    );

    assign instruction = imem[pc_out[7:2]];

    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] res);
        exp_t e;
        e.pc  = pc;
        e.res = res;
        q.push_back(e);
    endtask

    task automatic drain(input string phase);
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d entries left, expected 0", phase, q.size());
            q.delete();
        end
    endtask

    // Monitor: one expected entry per cycle while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("pc_out[%0d]", n_pop), pc_out, e.pc);
                chk($sformatf("res_out[%0d]", n_pop), res_out, e.res);
                n_pop++;
            end
        end
    end

    logic [31:0] p1_pc  [26] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
                                 32'h24, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C,
                                 32'h50, 32'h54, 32'h58, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70};
    logic [31:0] p1_res [26] = '{32'h0, 32'h5, 32'hFFFF_FFFD, 32'h2, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFD,
                                 32'h0, 32'h24, 32'h0, 32'h2, 32'h0, 32'h8000_0000, 32'hF800_0000,
                                 32'h0800_0000, 32'h7, 32'h0, 32'h0, 32'h1050, 32'h58, 32'h0, 32'h1,
                                 32'h0, 32'h0, 32'h1};

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        imem[0]  = 32'h0050_0093; // addi x1,x0,5
        imem[1]  = 32'hFFD0_0113; // addi x2,x0,-3
        imem[2]  = 32'h0020_81B3; // add  x3,x1,x2
        imem[3]  = 32'h0011_2233; // slt  x4,x2,x1
        imem[4]  = 32'h0000_0463; // beq  x0,x0,+8
        imem[5]  = 32'h0630_0113; // addi x2,x0,99 (flushed)
        imem[6]  = 32'h0001_03B3; // add  x7,x2,x0
        imem[7]  = 32'h0030_2423; // sw   x3,8(x0)
        imem[8]  = 32'h0100_00EF; // jal  x1,+16
        imem[9]  = 32'h0630_0113; // addi x2,x0,99 (flushed)
        imem[12] = 32'h0080_2283; // lw   x5,8(x0)
        imem[13] = 32'h0011_3233; // sltu x4,x2,x1
        imem[14] = 32'h8000_0437; // lui  x8,0x80000
        imem[15] = 32'h4044_5493; // srai x9,x8,4
        imem[16] = 32'h0044_5493; // srli x9,x8,4
        imem[17] = 32'h0070_0013; // addi x0,x0,7
        imem[18] = 32'h0000_0533; // add  x10,x0,x0
        imem[19] = 32'h0000_1463; // bne  x0,x0,+8 (not taken)
        imem[20] = 32'h0000_1597; // auipc x11,1
        imem[21] = 32'h03D0_8667; // jalr x12,0x3D(x1) -> 0x60
        imem[22] = 32'h0370_0693; // addi x13,x0,55 (flushed)
        imem[24] = 32'h0010_0693; // addi x13,x0,1
        imem[25] = 32'h0020_E463; // bltu x1,x2,+8 (taken)
        imem[26] = 32'h0370_0693; // addi x13,x0,55 (flushed)
        imem[27] = 32'h0006_8733; // add  x14,x13,x0
        for (int i = 0; i < 26; i++) push(p1_pc[i], p1_res[i]);
        #9;
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset res_out", res_out, 32'h0);
        #1 rst = 1'b1;
        drain("program1");

        // Asynchronous reset mid-run, then prove the register file was cleared.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async reset pc_out", pc_out, 32'h0);
        chk("async reset res_out", res_out, 32'h0);
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        imem[0] = 32'h0053_87B3; // add  x15,x7,x5 -> 0 only if x7,x5 were cleared
        imem[1] = 32'h0070_0013; // addi x0,x0,7
        imem[2] = 32'h0000_0833; // add  x16,x0,x0
        push(32'h0, 32'h0);
        push(32'h4, 32'h0);
        push(32'h8, 32'h7);
        push(32'hC, 32'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        drain("program2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
